// File: rtl/sobel_engine.sv
// Streaming 3x3 Sobel stage: raster-reads a loaded frame once and writes the gradient magnitude of every
// interior pixel back in place. Define SOBEL_THRESH_EN to emit a binary edge map (mag >= THRESH) instead.
module sobel_engine #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int RD_LAT = 2,
  parameter int THRESH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] read_H,
  output logic [15:0] read_W,
  input  logic [7:0]  rd_data,
  output logic [7:0]  write_data,
  output logic        transmit_valid,
  output logic [15:0] counter_H,
  output logic [15:0] counter_W,
  output logic        sobel_ready
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  if (IMG_W < 3 || IMG_H < 3 || RD_LAT < 1 || THRESH < 0 || THRESH > 2040) begin : g_bad_params
    $error("sobel_engine: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t      r_state;
  logic [15:0] r_scan_h, r_scan_w;
  logic        r_rd_valid;
  logic [7:0]  r_drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_scan_h    <= '0;
      r_scan_w    <= '0;
      r_rd_valid  <= 1'b0;
      r_drain     <= '0;
      read_H      <= '0;
      read_W      <= '0;
      sobel_ready <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state  <= SCAN;
          r_scan_h <= '0;
          r_scan_w <= '0;
        end
        SCAN: begin
          read_H     <= r_scan_h;
          read_W     <= r_scan_w;
          r_rd_valid <= 1'b1;
          if (r_scan_w == 16'(IMG_W - 1)) begin
            r_scan_w <= '0;
            r_scan_h <= r_scan_h + 16'd1;
            if (r_scan_h == 16'(IMG_H - 1)) begin
              r_state <= DRAIN;
              r_drain <= '0;
            end
          end else begin
            r_scan_w <= r_scan_w + 16'd1;
          end
        end
        // Wait until the last pixel has left stage 2 before releasing the BRAM.
        DRAIN: if (r_drain == 8'(RD_LAT + 2)) begin
          r_state     <= DONE;
          sobel_ready <= 1'b1;
        end else begin
          r_drain <= r_drain + 8'd1;
        end
        DONE:    sobel_ready <= 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end

  logic        r_pv [RD_LAT];
  logic [15:0] r_ph [RD_LAT];
  logic [15:0] r_pw [RD_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_ph[i] <= '0;
        r_pw[i] <= '0;
      end
    end else begin
      r_pv[0] <= r_rd_valid;
      r_ph[0] <= read_H;
      r_pw[0] <= read_W;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_ph[i] <= r_ph[i-1];
        r_pw[i] <= r_pw[i-1];
      end
    end
  end

  logic          w_av;
  logic [15:0]   w_ah, w_aw;
  logic [AW-1:0] w_idx;
  assign w_av  = r_pv[RD_LAT-1];
  assign w_ah  = r_ph[RD_LAT-1];
  assign w_aw  = r_pw[RD_LAT-1];
  assign w_idx = w_aw[AW-1:0];

  // LB0 holds the previous row, LB1 the one before it; both are read before this cycle's write.
  logic [7:0] r_lb0 [IMG_W];
  logic [7:0] r_lb1 [IMG_W];
  always_ff @(posedge clk) begin
    if (w_av) begin
      r_lb0[w_idx] <= rd_data;
      r_lb1[w_idx] <= r_lb0[w_idx];
    end
  end

  logic [7:0] w_top, w_mid, w_bot;
  assign w_top = r_lb1[w_idx];
  assign w_mid = r_lb0[w_idx];
  assign w_bot = rd_data;

  logic [7:0] r_cl_t, r_cl_m, r_cl_b, r_cm_t, r_cm_m, r_cm_b;
  logic [9:0] w_sum_r, w_sum_l, w_sum_bt, w_sum_tp;
  logic signed [11:0] w_gx, w_gy;

  assign w_sum_r  = 10'(w_top) + {1'b0, w_mid, 1'b0} + 10'(w_bot);
  assign w_sum_l  = 10'(r_cl_t) + {1'b0, r_cl_m, 1'b0} + 10'(r_cl_b);
  assign w_sum_bt = 10'(r_cl_b) + {1'b0, r_cm_b, 1'b0} + 10'(w_bot);
  assign w_sum_tp = 10'(r_cl_t) + {1'b0, r_cm_t, 1'b0} + 10'(w_top);
  assign w_gx     = $signed({2'b00, w_sum_r}) - $signed({2'b00, w_sum_l});
  assign w_gy     = $signed({2'b00, w_sum_bt}) - $signed({2'b00, w_sum_tp});

  logic signed [10:0] r_gx, r_gy;
  logic               r_s1_v;
  logic [15:0]        r_s1_h, r_s1_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_cl_t, r_cl_m, r_cl_b, r_cm_t, r_cm_m, r_cm_b} <= '0;
      r_gx   <= '0;
      r_gy   <= '0;
      r_s1_v <= 1'b0;
      r_s1_h <= '0;
      r_s1_w <= '0;
    end else begin
      r_s1_v <= w_av && (w_ah >= 16'd2) && (w_aw >= 16'd2);
      if (w_av) begin
        {r_cl_t, r_cl_m, r_cl_b} <= {r_cm_t, r_cm_m, r_cm_b};
        {r_cm_t, r_cm_m, r_cm_b} <= {w_top, w_mid, w_bot};
        r_gx   <= w_gx[10:0];
        r_gy   <= w_gy[10:0];
        r_s1_h <= w_ah - 16'd1;
        r_s1_w <= w_aw - 16'd1;
      end
    end
  end

  logic [10:0] w_ax, w_ay;
  logic [11:0] w_mag;
  logic [7:0]  w_pix;
  assign w_ax  = r_gx[10] ? (~r_gx + 11'd1) : r_gx;
  assign w_ay  = r_gy[10] ? (~r_gy + 11'd1) : r_gy;
  assign w_mag = {1'b0, w_ax} + {1'b0, w_ay};
`ifdef SOBEL_THRESH_EN
  assign w_pix = (w_mag >= 12'(THRESH)) ? 8'hFF : 8'h00;
`else
  assign w_pix = (w_mag > 12'd255) ? 8'hFF : w_mag[7:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_data     <= '0;
      transmit_valid <= 1'b0;
      counter_H      <= '0;
      counter_W      <= '0;
    end else begin
      transmit_valid <= r_s1_v;
      if (r_s1_v) begin
        write_data <= w_pix;
        counter_H  <= r_s1_h;
        counter_W  <= r_s1_w;
      end
    end
  end

endmodule

// File: tb/tb_sobel_engine.sv
// Randomised and directed frames through sobel_engine with a behavioural BRAM and a plain-arithmetic
// convolution reference; checks strobe order/values, latency, burst pattern, in-place safety and final memory.
module tb_sobel_engine;
  localparam int W = 8, H = 6, LAT = 2, TH = 64, N = W * H;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [15:0] read_H, read_W, counter_H, counter_W;
  logic [7:0]  rd_data, write_data, d1;
  logic        transmit_valid, sobel_ready;

  always #5 clk = ~clk;

  sobel_engine #(.IMG_W(W), .IMG_H(H), .RD_LAT(LAT), .THRESH(TH)) dut (
    .clk(clk), .reset(reset), .start(start), .read_H(read_H), .read_W(read_W),
    .rd_data(rd_data), .write_data(write_data), .transmit_valid(transmit_valid),
    .counter_H(counter_H), .counter_W(counter_W), .sobel_ready(sobel_ready)
  );

  logic [7:0] src [N];
  logic [7:0] mem [N];
  int         exp_mem [N];
  logic       load = 1'b0;
  int         cyc = 0;
  int         n_checks = 0, n_fail = 0;

  // Two-cycle BRAM: address registered by the DUT, then two register stages here.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= src[i];
    end else if (transmit_valid) begin
      mem[int'(counter_H) * W + int'(counter_W)] <= write_data;
    end
    d1      <= mem[(int'(read_H) * W + int'(read_W)) % N];
    rd_data <= d1;
  end

  typedef struct { int h; int w; int d; int cyc; int safe; } ev_t;
  ev_t ev_q[$];
  logic mon_en = 1'b0;
  int t22 = -1, t57 = -1, trdy = -1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (transmit_valid)
        ev_q.push_back('{int'(counter_H), int'(counter_W), int'(write_data), cyc,
                         int'(int'(counter_H) * W + int'(counter_W) < int'(read_H) * W + int'(read_W))});
      if (read_H == 16'd2 && read_W == 16'd2 && t22 < 0) t22 = cyc;
      if (read_H == 16'(H-1) && read_W == 16'(W-1) && t57 < 0) t57 = cyc;
      if (sobel_ready && trdy < 0) trdy = cyc;
    end
  end

  task automatic check(input string tag, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  function automatic int px(int h, int w);
    return int'(src[h * W + w]);
  endfunction

  task automatic build_expected();
    int gx, gy, mag;
    for (int i = 0; i < N; i++) exp_mem[i] = int'(src[i]);
    for (int h = 1; h < H - 1; h++)
      for (int w = 1; w < W - 1; w++) begin
        gx = 0; gy = 0;
        for (int d = -1; d <= 1; d++) begin
          gx += (d == 0 ? 2 : 1) * (px(h + d, w + 1) - px(h + d, w - 1));
          gy += (d == 0 ? 2 : 1) * (px(h + 1, w + d) - px(h - 1, w + d));
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
        exp_mem[h * W + w] = (mag >= TH) ? 255 : 0;
`else
        exp_mem[h * W + w] = (mag > 255) ? 255 : mag;
`endif
      end
  endtask

  task automatic fill(input int kind);
    for (int h = 0; h < H; h++)
      for (int w = 0; w < W; w++)
        case (kind)
          0: src[h * W + w] = 8'h80;
          1: src[h * W + w] = (w >= 4) ? 8'hFF : 8'h00;
          2: src[h * W + w] = 8'(10 * w);
          3: src[h * W + w] = 8'($urandom_range(0, 255));
          default: src[h * W + w] = $urandom_range(0, 1) ? 8'hFF : 8'h00;
        endcase
  endtask

  task automatic do_load();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "/read_H"}, int'(read_H), 0);
    check({nm, "/read_W"}, int'(read_W), 0);
    check({nm, "/write_data"}, int'(write_data), 0);
    check({nm, "/transmit_valid"}, int'(transmit_valid), 0);
    check({nm, "/counter_H"}, int'(counter_H), 0);
    check({nm, "/counter_W"}, int'(counter_W), 0);
    check({nm, "/sobel_ready"}, int'(sobel_ready), 0);
  endtask

  task automatic run_frame(input string nm);
    int k;
    build_expected();
    do_load();
    ev_q.delete();
    t22 = -1; t57 = -1; trdy = -1;
    mon_en = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 400 && !sobel_ready; i++) @(negedge clk);
    check({nm, "/ready_reached"}, int'(sobel_ready), 1);
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    check({nm, "/strobes"}, ev_q.size(), (H - 2) * (W - 2));
    k = 0;
    for (int h = 1; h < H - 1; h++)
      for (int w = 1; w < W - 1; w++) begin
        if (k < ev_q.size()) begin
          check($sformatf("%s/s%0d_h", nm, k), ev_q[k].h, h);
          check($sformatf("%s/s%0d_w", nm, k), ev_q[k].w, w);
          check($sformatf("%s/s%0d_data", nm, k), ev_q[k].d, exp_mem[h * W + w]);
          check($sformatf("%s/s%0d_behind_read", nm, k), ev_q[k].safe, 1);
          if (k > 0)
            check($sformatf("%s/s%0d_gap", nm, k), ev_q[k].cyc - ev_q[k-1].cyc, (w == 1) ? 3 : 1);
        end
        k++;
      end
    check({nm, "/first_latency"}, (ev_q.size() > 0 && t22 >= 0) ? ev_q[0].cyc - t22 : -1, LAT + 2);
    check({nm, "/ready_latency"}, (trdy >= 0 && t57 >= 0) ? trdy - t57 : -1, LAT + 3);
    for (int i = 0; i < N; i++)
      check($sformatf("%s/mem%0d", nm, i), int'(mem[i]), exp_mem[i]);
    $display("frame %s: strobes=%0d first_lat=%0d ready_lat=%0d", nm, ev_q.size(),
             (ev_q.size() > 0) ? ev_q[0].cyc - t22 : -1, trdy - t57);
  endtask

  initial begin
    bit seen;
    #2 reset = 1'b1;
    #1 check_outputs_zero("reset");
    @(negedge clk) reset = 1'b0;

    fill(0); run_frame("uniform");
    do_reset(); fill(1); run_frame("vstep");
    do_reset(); fill(2); run_frame("ramp");
    do_reset(); fill(3); run_frame("random_a");
    do_reset(); fill(3); run_frame("random_b");
    do_reset(); fill(4); run_frame("random_bin");

    // Abort a frame in row 3, then reprocess the ramp from scratch.
    do_reset(); fill(2); do_load();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (read_H == 16'd3);
    end
    check("midreset/row3_reached", int'(seen), 1);
    reset = 1'b1;
    #1 check_outputs_zero("midreset");
    @(negedge clk) reset = 1'b0;
    run_frame("ramp_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
